// File: rtl/hififo_pkg.sv
// rtl/hififo_pkg.sv - shared state encoding, control bit indices and LFSR seed
package hififo_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SYNC  = 2'd1,
    ST_CHECK = 2'd2,
    ST_HALT  = 2'd3
  } state_e;

  localparam int CTRL_EN_BIT   = 0;
  localparam int CTRL_CLR_BIT  = 1;
  localparam int CTRL_HALT_BIT = 2;
  localparam int CTRL_THR_BIT  = 3;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;

endpackage

// File: rtl/lfsr16.sv
// rtl/lfsr16.sv - 16-bit Fibonacci LFSR (taps 16,14,13,11), advances every cycle
module lfsr16
  import hififo_pkg::*;
(
  input  logic clock,
  input  logic rst_n,
  output logic bit_o
);

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;

  // Right-shifting form: taps 16,14,13,11 land on bits 0,2,3,5.
  assign lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
  assign bit_o  = lfsr_q[0];

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

endmodule

// File: rtl/fifo_seq_checker.sv
// rtl/fifo_seq_checker.sv - incrementing-sequence checker on a FWFT FIFO with PIO control
// FIFO_SEQ_CHECKER_THROTTLE_EN enables LFSR read throttling via control bit3.
module fifo_seq_checker
  import hififo_pkg::*;
#(
  parameter logic [12:0] CTRL_ADDR = 13'd16,
  parameter int          CNT_W     = 32
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic [63:0]      fpc_data,
  input  logic             fpc_empty,
  output logic             fpc_read,
  input  logic             pio_write_valid,
  input  logic [12:0]      pio_address,
  input  logic [63:0]      pio_write_data,
  output logic [CNT_W-1:0] word_count,
  output logic [CNT_W-1:0] error_count,
  output logic [63:0]      first_err,
  output logic [1:0]       state
);

  state_e           state_q, state_d;
  logic [63:0]      expected_q, expected_d;
  logic [CNT_W-1:0] wc_q, wc_d;
  logic [CNT_W-1:0] ec_q, ec_d;
  logic [63:0]      fe_q, fe_d;
  logic             enable_q, enable_d;
  logic             halt_q, halt_d;
  logic             throttle_q;
  logic             lfsr_bit;
  logic             ctrl_wr, clear, consume, mismatch;
  logic             unused_ctrl;

`ifdef FIFO_SEQ_CHECKER_THROTTLE_EN
  logic throttle_d;

  assign throttle_d  = ctrl_wr ? pio_write_data[CTRL_THR_BIT] : throttle_q;
  assign unused_ctrl = &{1'b0, pio_write_data[63:4]};

  lfsr16 u_lfsr (
    .clock (clock),
    .rst_n (rst_n),
    .bit_o (lfsr_bit)
  );

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      throttle_q <= 1'b0;
    end else begin
      throttle_q <= throttle_d;
    end
  end
`else
  assign throttle_q  = 1'b0;
  assign lfsr_bit    = 1'b0;
  assign unused_ctrl = &{1'b0, pio_write_data[63:4], pio_write_data[CTRL_THR_BIT]};
`endif

  assign fpc_read    = ((state_q == ST_SYNC) || (state_q == ST_CHECK)) && (!throttle_q || lfsr_bit);
  assign word_count  = wc_q;
  assign error_count = ec_q;
  assign first_err   = fe_q;
  assign state       = state_q;

  always_comb begin
    ctrl_wr    = pio_write_valid && (pio_address == CTRL_ADDR);
    clear      = ctrl_wr && pio_write_data[CTRL_CLR_BIT];
    enable_d   = ctrl_wr ? pio_write_data[CTRL_EN_BIT] : enable_q;
    halt_d     = ctrl_wr ? pio_write_data[CTRL_HALT_BIT] : halt_q;
    consume    = fpc_read && !fpc_empty;
    mismatch   = consume && (state_q == ST_CHECK) && (fpc_data != expected_q);
    state_d    = state_q;
    expected_d = expected_q;

    case (state_q)
      ST_IDLE:  if (enable_d) state_d = ST_SYNC;
      ST_SYNC: begin
        if (consume) begin
          expected_d = fpc_data + 64'd1;
          state_d    = ST_CHECK;
        end
      end
      ST_CHECK: begin
        // Always reload from the received word so a mismatch resynchronises.
        if (consume) begin
          expected_d = fpc_data + 64'd1;
          if (mismatch && halt_q) state_d = ST_HALT;
        end
      end
      default: state_d = state_q;
    endcase
    if (!enable_d) state_d = ST_IDLE;

    wc_d = (consume && (wc_q != '1)) ? wc_q + CNT_W'(1) : wc_q;
    ec_d = (mismatch && (ec_q != '1)) ? ec_q + CNT_W'(1) : ec_q;
    fe_d = (mismatch && (ec_q == '0)) ? fpc_data : fe_q;
    if (clear) begin
      wc_d = '0;
      ec_d = '0;
      fe_d = '0;
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      expected_q <= '0;
      wc_q       <= '0;
      ec_q       <= '0;
      fe_q       <= '0;
      enable_q   <= 1'b0;
      halt_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      expected_q <= expected_d;
      wc_q       <= wc_d;
      ec_q       <= ec_d;
      fe_q       <= fe_d;
      enable_q   <= enable_d;
      halt_q     <= halt_d;
    end
  end

endmodule

// File: tb/tb_fifo_seq_checker.sv
// tb/tb_fifo_seq_checker.sv - table-driven bench for fifo_seq_checker with a queue-based FWFT FIFO model
module tb_fifo_seq_checker;

  localparam logic [3:0] C_EN  = 4'b0001;
  localparam logic [3:0] C_CLR = 4'b0010;
  localparam logic [3:0] C_HLT = 4'b0100;
  localparam logic [3:0] C_THR = 4'b1000;

  logic        clock = 1'b0;
  logic        rst_n = 1'b0;
  logic [63:0] fpc_data = '0;
  logic        fpc_empty = 1'b1;
  logic        fpc_read;
  logic        pio_write_valid = 1'b0;
  logic [12:0] pio_address = '0;
  logic [63:0] pio_write_data = '0;
  logic [31:0] word_count, error_count;
  logic [63:0] first_err;
  logic [1:0]  state;

  logic [63:0] fq[$];
  logic        pend = 1'b0;
  int          n_cmp = 0;
  int          n_fail = 0;

  typedef struct {
    logic [3:0]        ctrl;
    int                n;
    logic [0:5][63:0]  w;
    logic [31:0]       wc;
    logic [31:0]       ec;
    logic [63:0]       fe;
    logic [1:0]        st;
    int                left;
  } vec_t;

  vec_t vt[6];

  fifo_seq_checker #(.CTRL_ADDR(13'd16), .CNT_W(32)) dut (
    .clock           (clock),
    .rst_n           (rst_n),
    .fpc_data        (fpc_data),
    .fpc_empty       (fpc_empty),
    .fpc_read        (fpc_read),
    .pio_write_valid (pio_write_valid),
    .pio_address     (pio_address),
    .pio_write_data  (pio_write_data),
    .word_count      (word_count),
    .error_count     (error_count),
    .first_err       (first_err),
    .state           (state)
  );

  always #5 clock = ~clock;

  // FIFO model: a word read at a rising edge is popped at the following falling edge.
  always @(negedge clock) begin
    if (!rst_n) begin
      pend = 1'b0;
    end else begin
      if (pend) void'(fq.pop_front());
      fpc_empty = (fq.size() == 0);
      fpc_data  = fpc_empty ? 64'd0 : fq[0];
      pend      = fpc_read && !fpc_empty;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic pio_write(input logic [12:0] addr, input logic [3:0] ctrl);
    pio_write_valid = 1'b1;
    pio_address     = addr;
    pio_write_data  = {60'd0, ctrl};
    tick();
    pio_write_valid = 1'b0;
    pio_write_data  = '0;
  endtask

  task automatic restart();
    pio_write(13'd16, 4'b0000);
    tick();
    tick();
    fq.delete();
    pio_write(13'd16, C_CLR);
  endtask

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (fq.size() == 0) break;
      tick();
    end
    check("drain_timeout", 64'(fq.size()), 64'd0);
    tick();
    tick();
  endtask

  initial begin
    vt[0] = '{C_EN, 6, {64'd5, 64'd6, 64'd7, 64'd42, 64'd43, 64'd44}, 32'd6, 32'd1, 64'd42, 2'd2, 0};
    vt[1] = '{C_EN, 4, {64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 64'd1, 64'd0, 64'd0},
              32'd4, 32'd0, 64'd0, 2'd2, 0};
    vt[2] = '{C_EN | C_HLT, 4, {64'd1, 64'd2, 64'd9, 64'd10, 64'd0, 64'd0}, 32'd3, 32'd1, 64'd9, 2'd3, 1};
    vt[3] = '{C_EN, 4, {64'd10, 64'd20, 64'd30, 64'd31, 64'd0, 64'd0}, 32'd4, 32'd2, 64'd20, 2'd2, 0};
    vt[4] = '{4'b0000, 2, {64'd3, 64'd4, 64'd0, 64'd0, 64'd0, 64'd0}, 32'd0, 32'd0, 64'd0, 2'd0, 2};
    vt[5] = '{C_EN, 1, {64'd7, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0}, 32'd1, 32'd0, 64'd0, 2'd2, 0};

    repeat (3) @(posedge clock);
    #2;
    rst_n = 1'b1;
    tick();
    check("reset_state", 64'(state), 64'd0);
    check("reset_read", 64'(fpc_read), 64'd0);
    check("reset_wc", 64'(word_count), 64'd0);
    check("reset_ec", 64'(error_count), 64'd0);
    check("reset_fe", first_err, 64'd0);

    for (int v = 0; v < 6; v++) begin
      restart();
      pio_write(13'd16, vt[v].ctrl);
      for (int k = 0; k < vt[v].n; k++) fq.push_back(vt[v].w[k]);
      repeat (vt[v].n + 8) tick();
      check($sformatf("v%0d_wc", v), 64'(word_count), 64'(vt[v].wc));
      check($sformatf("v%0d_ec", v), 64'(error_count), 64'(vt[v].ec));
      check($sformatf("v%0d_fe", v), first_err, vt[v].fe);
      check($sformatf("v%0d_state", v), 64'(state), 64'(vt[v].st));
      check($sformatf("v%0d_left", v), 64'(fq.size()), 64'(vt[v].left));
      if (vt[v].st == 2'd3) check($sformatf("v%0d_halt_read", v), 64'(fpc_read), 64'd0);
    end

    // A write to another address must not touch control.
    restart();
    pio_write(13'd17, C_EN);
    tick();
    check("wrong_addr_state", 64'(state), 64'd0);

    // 0..99 straight run.
    restart();
    pio_write(13'd16, C_EN);
    for (int k = 0; k < 100; k++) fq.push_back(64'(k));
    wait_drain(500);
    check("run100_wc", 64'(word_count), 64'd100);
    check("run100_ec", 64'(error_count), 64'd0);
    check("run100_state", 64'(state), 64'd2);

    // Clear in the same cycle as a mismatching consume wins.
    restart();
    pio_write(13'd16, C_EN);
    fq.push_back(64'd1); fq.push_back(64'd2); fq.push_back(64'd3); fq.push_back(64'd8);
    wait_drain(50);
    check("pre_clear_ec", 64'(error_count), 64'd1);
    check("pre_clear_fe", first_err, 64'd8);
    fq.push_back(64'd50);
    pio_write_valid = 1'b1;
    pio_address     = 13'd16;
    pio_write_data  = {60'd0, C_EN | C_CLR};
    tick();
    pio_write_valid = 1'b0;
    pio_write_data  = '0;
    check("clr_hit_wc", 64'(word_count), 64'd0);
    check("clr_hit_ec", 64'(error_count), 64'd0);
    check("clr_hit_fe", first_err, 64'd0);
    fq.push_back(64'd51);
    wait_drain(50);
    check("post_clear_wc", 64'(word_count), 64'd1);
    check("post_clear_ec", 64'(error_count), 64'd0);

    // Asynchronous reset mid-stream with throttling, then a long run.
    restart();
    pio_write(13'd16, C_EN | C_THR);
    for (int k = 0; k < 50; k++) fq.push_back(64'(k));
    repeat (20) tick();
    rst_n = 1'b0;
    #1;
    check("arst_state", 64'(state), 64'd0);
    check("arst_read", 64'(fpc_read), 64'd0);
    check("arst_wc", 64'(word_count), 64'd0);
    check("arst_ec", 64'(error_count), 64'd0);
    check("arst_fe", first_err, 64'd0);
    tick();
    fq.delete();
    tick();
    rst_n = 1'b1;
    tick();
    check("after_rst_state", 64'(state), 64'd0);
    pio_write(13'd16, C_EN | C_THR);
    for (int k = 0; k < 1000; k++) fq.push_back(64'(k));
    wait_drain(6000);
    check("run1000_wc", 64'(word_count), 64'd1000);
    check("run1000_ec", 64'(error_count), 64'd0);
    check("run1000_state", 64'(state), 64'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
